// File: rtl/jedro_1_lsu.sv
// jedro_1_lsu: load-store unit driving the req/gnt/rvalid data bus and returning aligned, extended load data
module jedro_1_lsu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  ctrl_valid_i,
  output logic                  ctrl_ready_o,
  input  logic                  ctrl_we_i,
  input  logic [1:0]            ctrl_width_i,
  input  logic                  ctrl_sign_ext_i,
  input  logic [DATA_WIDTH-1:0] ctrl_addr_i,
  input  logic [DATA_WIDTH-1:0] ctrl_wdata_i,
  input  logic [4:0]            ctrl_rd_addr_i,
  output logic                  rf_we_o,
  output logic [4:0]            rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic                  done_o,
  output logic                  misaligned_o,
  output logic                  err_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [DATA_WIDTH-1:0] data_addr_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  input  logic [DATA_WIDTH-1:0] data_rdata_i,
  input  logic                  data_err_i
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2;
  logic [1:0] state, off, width;
  logic sgn, bad;
  logic [4:0] rd;
  logic [DATA_WIDTH-1:0] sh, ld, wrep;
  logic [3:0] be;
  always_comb begin
    bad  = (ctrl_width_i == 2'd3) || (ctrl_width_i == 2'd1 && ctrl_addr_i[0]) ||
           (ctrl_width_i == 2'd2 && ctrl_addr_i[1:0] != 2'd0);
    be   = ctrl_width_i == 2'd0 ? 4'b0001 << ctrl_addr_i[1:0] :
           ctrl_width_i == 2'd1 ? 4'b0011 << ctrl_addr_i[1:0] : 4'b1111;
    wrep = ctrl_width_i == 2'd0 ? {4{ctrl_wdata_i[7:0]}} :
           ctrl_width_i == 2'd1 ? {2{ctrl_wdata_i[15:0]}} : ctrl_wdata_i;
    sh   = data_rdata_i >> {off, 3'b000};
    ld   = width == 2'd0 ? {{24{sgn & sh[7]}}, sh[7:0]} :
           width == 2'd1 ? {{16{sgn & sh[15]}}, sh[15:0]} : sh;
  end
  assign ctrl_ready_o = state == IDLE;
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state        <= IDLE;
      off          <= '0;
      width        <= '0;
      sgn          <= 1'b0;
      rd           <= '0;
      data_req_o   <= 1'b0;
      data_we_o    <= 1'b0;
      data_be_o    <= '0;
      data_addr_o  <= '0;
      data_wdata_o <= '0;
      rf_we_o      <= 1'b0;
      rf_waddr_o   <= '0;
      rf_wdata_o   <= '0;
      done_o       <= 1'b0;
      misaligned_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      rf_we_o      <= 1'b0;
      done_o       <= 1'b0;
      misaligned_o <= 1'b0;
      err_o        <= 1'b0;
      case (state)
        IDLE: if (ctrl_valid_i) begin
          if (bad) begin
            misaligned_o <= 1'b1;
            done_o       <= 1'b1;
          end else begin
            state        <= REQ;
            data_req_o   <= 1'b1;
            data_we_o    <= ctrl_we_i;
            data_be_o    <= be;
            data_addr_o  <= {ctrl_addr_i[DATA_WIDTH-1:2], 2'b00};
            data_wdata_o <= wrep;
            off          <= ctrl_addr_i[1:0];
            width        <= ctrl_width_i;
            sgn          <= ctrl_sign_ext_i;
            rd           <= ctrl_rd_addr_i;
          end
        end
        REQ: if (data_gnt_i) begin
          data_req_o <= 1'b0;
          state      <= WAIT;
        end
        WAIT: if (data_rvalid_i) begin
          state  <= IDLE;
          done_o <= 1'b1;
          if (data_err_i) err_o <= 1'b1;
          else if (!data_we_o) begin
            rf_we_o    <= 1'b1;
            rf_waddr_o <= rd;
            rf_wdata_o <= ld;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jedro_1_lsu.sv
// tb_jedro_1_lsu: directed table plus randomized transactions checked against a byte-level model
module tb_jedro_1_lsu;
  logic clk = 0, rstn = 0;
  logic ctrl_valid = 0, ctrl_we = 0, ctrl_sign = 0;
  logic [1:0] ctrl_width = 0;
  logic [31:0] ctrl_addr = 0, ctrl_wdata = 0;
  logic [4:0] ctrl_rd = 0;
  logic ctrl_ready, rf_we, done, mis, err;
  logic [4:0] rf_waddr;
  logic [31:0] rf_wdata;
  logic data_req, data_we, data_gnt = 0, data_rvalid = 0, data_err = 0;
  logic [3:0] data_be;
  logic [31:0] data_addr, data_wdata, data_rdata = 0;
  int vecs = 0, errs = 0;
  logic [31:0] last_rf = 0;

  typedef struct {
    logic we; logic [1:0] w; logic s; logic [31:0] a, wd; logic [4:0] rdst;
    int gd, rdl; logic [31:0] rdata; logic err, spur;
    logic x_mis; logic [3:0] x_be; logic [31:0] x_addr, x_wd, x_rf; logic x_rfwe, x_err;
  } vec_t;

  jedro_1_lsu dut (
    .clk_i(clk), .rstn_i(rstn), .ctrl_valid_i(ctrl_valid), .ctrl_ready_o(ctrl_ready),
    .ctrl_we_i(ctrl_we), .ctrl_width_i(ctrl_width), .ctrl_sign_ext_i(ctrl_sign),
    .ctrl_addr_i(ctrl_addr), .ctrl_wdata_i(ctrl_wdata), .ctrl_rd_addr_i(ctrl_rd),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata), .done_o(done),
    .misaligned_o(mis), .err_o(err), .data_req_o(data_req), .data_gnt_i(data_gnt),
    .data_rvalid_i(data_rvalid), .data_we_o(data_we), .data_be_o(data_be),
    .data_addr_o(data_addr), .data_wdata_o(data_wdata), .data_rdata_i(data_rdata),
    .data_err_i(data_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset();
    chk("rst_ready", ctrl_ready, 1);
    chk("rst_req", data_req, 0);
    chk("rst_we", data_we, 0);
    chk("rst_be", data_be, 0);
    chk("rst_addr", data_addr, 0);
    chk("rst_wdata", data_wdata, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_waddr", rf_waddr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_done", done, 0);
    chk("rst_mis", mis, 0);
    chk("rst_err", err, 0);
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] w, input logic s,
      input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rdst, input int gd,
      input int rdl, input logic [31:0] rdata, input logic e, input logic spur,
      input logic x_mis, input logic [3:0] x_be, input logic [31:0] x_addr,
      input logic [31:0] x_wd, input logic [31:0] x_rf, input logic x_rfwe, input logic x_err);
    vec_t v;
    v.we = we; v.w = w; v.s = s; v.a = a; v.wd = wd; v.rdst = rdst; v.gd = gd; v.rdl = rdl;
    v.rdata = rdata; v.err = e; v.spur = spur; v.x_mis = x_mis; v.x_be = x_be;
    v.x_addr = x_addr; v.x_wd = x_wd; v.x_rf = x_rf; v.x_rfwe = x_rfwe; v.x_err = x_err;
    return v;
  endfunction

  // Reference: an access covers bytes [off, off+size) of the word; loads gather those bytes.
  function automatic vec_t model(input vec_t v, input logic [31:0] prev_rf);
    vec_t r = v;
    int sz = 1 << v.w;
    int off = int'(v.a[1:0]);
    logic [31:0] val = 0;
    r.x_mis = (v.w == 2'd3) || (off % sz) != 0;
    r.x_addr = v.a & ~32'd3;
    r.x_be = 0;
    r.x_wd = 0;
    if (!r.x_mis) begin
      for (int i = 0; i < 4; i++) begin
        if (i >= off && i < off + sz) r.x_be[i] = 1'b1;
        r.x_wd[8*i +: 8] = v.wd[8*(i % sz) +: 8];
      end
      for (int i = 0; i < sz; i++) val[8*i +: 8] = v.rdata[8*(off+i) +: 8];
      if (v.s && sz < 4 && val[8*sz-1])
        for (int i = 8*sz; i < 32; i++) val[i] = 1'b1;
    end
    r.x_rfwe = !r.x_mis && !v.we && !v.err;
    r.x_err = !r.x_mis && v.err;
    r.x_rf = r.x_rfwe ? val : prev_rf;
    return r;
  endfunction

  task automatic run(input vec_t v);
    chk("ready_before", ctrl_ready, 1);
    ctrl_valid = 1; ctrl_we = v.we; ctrl_width = v.w; ctrl_sign = v.s;
    ctrl_addr = v.a; ctrl_wdata = v.wd; ctrl_rd = v.rdst;
    step();
    ctrl_valid = 0;
    chk("misaligned", mis, v.x_mis);
    if (v.x_mis) begin
      chk("mis_done", done, 1);
      chk("mis_req", data_req, 0);
      chk("mis_ready", ctrl_ready, 1);
      chk("mis_rf_we", rf_we, 0);
      return;
    end
    chk("acc_done", done, 0);
    chk("acc_ready", ctrl_ready, 0);
    for (int g = 0; g <= v.gd; g++) begin
      chk("req", data_req, 1);
      chk("addr", data_addr, v.x_addr);
      chk("be", data_be, v.x_be);
      chk("wdata", data_wdata, v.x_wd);
      chk("we", data_we, v.we);
      if (g < v.gd) begin
        data_gnt = 0;
        step();
      end
    end
    data_gnt = 1; data_rvalid = v.spur; data_rdata = ~v.rdata;
    step();
    data_gnt = 0; data_rvalid = 0;
    chk("req_drop", data_req, 0);
    chk("no_early_done", done, 0);
    for (int r = 0; r < v.rdl; r++) begin
      step();
      chk("wait_done", done, 0);
      chk("wait_ready", ctrl_ready, 0);
    end
    data_rvalid = 1; data_rdata = v.rdata; data_err = v.err;
    step();
    data_rvalid = 0; data_err = 0; data_rdata = 32'hA5A5_5A5A;
    chk("done", done, 1);
    chk("rf_we", rf_we, v.x_rfwe);
    chk("err", err, v.x_err);
    chk("rf_wdata", rf_wdata, v.x_rf);
    chk("end_ready", ctrl_ready, 1);
    if (v.x_rfwe) chk("rf_waddr", rf_waddr, v.rdst);
    last_rf = v.x_rf;
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = mk(0, 2, 0, 32'h1000, 0, 5'd1, 0, 0, 32'hDEADBEEF, 0, 0, 0, 4'hF, 32'h1000, 0, 32'hDEADBEEF, 1, 0);
    tbl[1] = mk(0, 0, 1, 32'h1003, 0, 5'd2, 0, 0, 32'h80FF0000, 0, 0, 0, 4'h8, 32'h1000, 0, 32'hFFFFFF80, 1, 0);
    tbl[2] = mk(0, 0, 0, 32'h1003, 0, 5'd3, 0, 0, 32'h80FF0000, 0, 0, 0, 4'h8, 32'h1000, 0, 32'h00000080, 1, 0);
    tbl[3] = mk(1, 1, 0, 32'h2002, 32'h0000ABCD, 5'd4, 4, 0, 32'h0, 0, 0, 0, 4'hC, 32'h2000, 32'hABCDABCD, 32'h00000080, 0, 0);
    tbl[4] = mk(0, 2, 0, 32'h1001, 0, 5'd5, 0, 0, 0, 0, 0, 1, 4'h0, 0, 0, 32'h00000080, 0, 0);
    tbl[5] = mk(0, 1, 0, 32'h1003, 0, 5'd6, 0, 0, 0, 0, 0, 1, 4'h0, 0, 0, 32'h00000080, 0, 0);
    tbl[6] = mk(0, 3, 0, 32'h1000, 0, 5'd7, 0, 0, 0, 0, 0, 1, 4'h0, 0, 0, 32'h00000080, 0, 0);
    tbl[7] = mk(0, 2, 0, 32'h3000, 0, 5'd8, 1, 2, 32'h12345678, 1, 0, 0, 4'hF, 32'h3000, 0, 32'h00000080, 0, 1);
    tbl[8] = mk(0, 1, 1, 32'h0002, 0, 5'd9, 0, 1, 32'h80010000, 0, 1, 0, 4'hC, 32'h0, 0, 32'hFFFF8001, 1, 0);

    #12;
    chk_reset();
    rstn = 1;
    step();
    data_rvalid = 1; data_rdata = 32'hFFFF_FFFF;
    step();
    data_rvalid = 0;
    chk("idle_rv_done", done, 0);
    chk("idle_rv_rf_we", rf_we, 0);
    chk("idle_rv_err", err, 0);
    chk("idle_rv_rf", rf_wdata, 0);

    foreach (tbl[i]) run(tbl[i]);

    for (int k = 0; k < 300; k++) begin
      vec_t v;
      v.we = 1'($urandom); v.w = 2'($urandom_range(0, 3)); v.s = 1'($urandom);
      v.a = $urandom; v.wd = $urandom; v.rdst = 5'($urandom); v.gd = $urandom_range(0, 3);
      v.rdl = $urandom_range(0, 3); v.rdata = $urandom; v.err = ($urandom_range(0, 7) == 0);
      v.spur = 1'($urandom);
      run(model(v, last_rf));
    end

    // Abort in REQ: request drops with reset, not at the next edge.
    run(model(mk(0, 2, 0, 32'h4000, 0, 5'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), last_rf));
    ctrl_valid = 1; ctrl_we = 0; ctrl_width = 2; ctrl_addr = 32'h5000;
    step();
    ctrl_valid = 0;
    chk("abort_req_up", data_req, 1);
    #2 rstn = 0;
    #1 chk_reset();
    #1 rstn = 1;
    step();
    ctrl_valid = 1; ctrl_width = 2; ctrl_addr = 32'h6000;
    step();
    ctrl_valid = 0;
    data_gnt = 1;
    step();
    data_gnt = 0;
    chk("wait_req_low", data_req, 0);
    #2 rstn = 0;
    #1 chk_reset();
    #1 rstn = 1;
    step();
    data_rvalid = 1; data_rdata = 32'h1234_5678;
    step();
    data_rvalid = 0;
    chk("late_rv_done", done, 0);
    chk("late_rv_rf_we", rf_we, 0);
    chk("late_rv_ready", ctrl_ready, 1);
    chk("late_rv_rf", rf_wdata, 0);
    last_rf = 0;
    run(model(mk(0, 0, 1, 32'h7001, 0, 5'd17, 2, 1, 32'h0000_9C00, 0, 0, 0, 0, 0, 0, 0, 0, 0), last_rf));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
